uart_tx_burst: RTL and testbench

Parametrised burst UART transmitter for the ASIC tester's host serial link. It latches a multi-byte payload and serialises a run-time selectable number of bytes as 8-bit frames. Each frame has an optional parity bit and one or two stop bits. The transmit/acknowledge handshake is the one the tester control FSM already drives, and the block replaces the fixed 16-byte, no-parity transmitter.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 16 +
 rtl/uart_tx_burst.sv | 81 ++++++++
 tb/tb_uart_tx_burst.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter/receiver blocks
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } tx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  localparam int CLKS_PER_BIT_115200 = 868;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-time counter, tick on the last cycle of each bit
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  logic [TW-1:0] cnt;
  assign tick = cnt == TW'(CLKS_PER_BIT - 1);
  always_ff @(posedge CLK) cnt <= (RST || clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_burst.sv
// uart_tx_burst: latches a multi-byte payload and sends LEN bytes as back-to-back 8-bit UART frames
module uart_tx_burst
  import uart_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [8*NUM_BYTES-1:0]             DATA,
  input  logic [$clog2(NUM_BYTES+1)-1:0]     LEN,
  input  logic                               CAPTURE,
  input  logic                               TRANSMIT,
  input  logic                               ACKNOWLEDGE,
  output logic                               TX,
  output logic                               BUSY,
  output logic                               BYTE_DONE,
  output logic                               SENT
);
  localparam int LW = $clog2(NUM_BYTES + 1);
  localparam logic [LW-1:0] NB = LW'(NUM_BYTES);
  localparam bit HAS_PAR = PARITY != PAR_NONE;
  tx_state_t state, state_n;
  logic [8*NUM_BYTES-1:0] pay_q;
  logic [LW-1:0] len_q, idx, eff;
  logic [2:0] bit_idx;
  logic [7:0] cur;
  logic tick, stop_last, frame_end, last_byte, par_bit;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .CLK(CLK),
    .RST(RST),
    .clear(state == ST_IDLE || state == ST_DONE),
    .tick(tick)
  );
  // A zero length (including the cleared post-reset value) means a full buffer
  assign eff = len_q == '0 ? NB : len_q;
  assign cur = pay_q[8*idx +: 8];
  assign par_bit = PARITY == PAR_EVEN ? ^cur : ~^cur;
  assign stop_last = bit_idx[0] == (STOP_BITS == 2);
  assign frame_end = state == ST_STOP && tick && stop_last;
  assign last_byte = idx == eff - 1'b1;
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (TRANSMIT) state_n = ST_START;
      ST_START:  if (tick) state_n = ST_DATA;
      ST_DATA:   if (tick && bit_idx == 3'd7) state_n = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_n = ST_STOP;
      ST_STOP:   if (frame_end) state_n = last_byte ? ST_DONE : ST_START;
      ST_DONE:   if (ACKNOWLEDGE) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) state <= RST ? ST_IDLE : state_n;
  // Outputs are registered from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      pay_q <= '0;
      len_q <= '0;
      idx <= '0;
      bit_idx <= '0;
      TX <= 1'b1;
      BUSY <= 1'b0;
      BYTE_DONE <= 1'b0;
      SENT <= 1'b0;
    end else begin
      if (state == ST_IDLE && CAPTURE) begin
        pay_q <= DATA;
        len_q <= (LEN == '0 || LEN > NB) ? NB : LEN;
      end
      idx <= state == ST_IDLE ? '0 : idx + LW'(frame_end);
      bit_idx <= state == ST_START ? '0 : bit_idx + 3'((state == ST_DATA || state == ST_STOP) && tick);
      TX <= state == ST_START ? 1'b0 : state == ST_DATA ? cur[bit_idx] : state == ST_PARITY ? par_bit : 1'b1;
      BUSY <= state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
      BYTE_DONE <= frame_end;
      SENT <= state == ST_DONE && !ACKNOWLEDGE;
    end
  end
endmodule

// File: tb/tb_uart_tx_burst.sv
// tb_uart_tx_burst: directed tests of the burst UART transmitter at 4 clocks per bit
module tb_uart_tx_burst;
  logic clk = 0, rst = 1;
  logic [127:0] data = '0;
  logic [4:0] len = '0;
  logic capture = 0, transmit = 0, ack = 0;
  logic [3:0] tx, busy, bd, sent;
  int vectors = 0, errors = 0;
  logic [7:0] eb [16];
  int en;
  always #5 clk = ~clk;
  // Instance 0: no parity; 1: even; 2: odd; 3: two stop bits
  for (genvar i = 0; i < 4; i++) begin : g_dut
    uart_tx_burst #(
      .NUM_BYTES(16), .CLKS_PER_BIT(4), .PARITY(i == 3 ? 0 : i), .STOP_BITS(i == 3 ? 2 : 1)
    ) u_dut (
      .CLK(clk), .RST(rst), .DATA(data), .LEN(len), .CAPTURE(capture), .TRANSMIT(transmit),
      .ACKNOWLEDGE(ack), .TX(tx[i]), .BUSY(busy[i]), .BYTE_DONE(bd[i]), .SENT(sent[i])
    );
  end
  // Expected {TX,BUSY,BYTE_DONE,SENT} at cycle c after the edge that sampled TRANSMIT
  function automatic logic [3:0] model(int par, int stops, int c);
    int nb = 10 + (par != 0 ? 1 : 0) + stops - 1;
    int fc = 4 * nb;
    int b, f, k;
    logic t = 1'b1;
    if (c >= 1 && (c - 1) / fc < en) begin
      b = (c - 1) / 4;
      f = b / nb;
      k = b % nb;
      if (k == 0) t = 1'b0;
      else if (k <= 8) t = eb[f][k-1];
      else if (k == 9 && par != 0) t = par == 1 ? ^eb[f] : ~^eb[f];
    end
    return {t, c >= 1 && c <= fc * en, c > 0 && c % fc == 0 && c <= fc * en, c > fc * en};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; capture = 0; transmit = 0; ack = 0;
    step(); step();
    rst = 0;
  endtask
  task automatic load(int n, int lenv);
    data = '0;
    for (int j = 0; j < n; j++) data[8*j +: 8] = eb[j];
    len = 5'(lenv);
    capture = 1;
    step();
    capture = 0;
  endtask
  task automatic go();
    transmit = 1;
    step();
    transmit = 0;
  endtask
  task automatic test_reset();
    rst = 1; transmit = 1;
    step(); step();
    vectors += 4;
    if (tx !== 4'hF) begin errors++; $display("FAIL reset_tx got=%b exp=1111", tx); end
    if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    if (bd !== 4'h0) begin errors++; $display("FAIL reset_byte_done got=%b exp=0000", bd); end
    if (sent !== 4'h0) begin errors++; $display("FAIL reset_sent got=%b exp=0000", sent); end
    rst = 0; transmit = 0;
    step();
    vectors++;
    if (tx !== 4'hF) begin errors++; $display("FAIL reset_idle_tx got=%b exp=1111", tx); end
  endtask
  task automatic test_basic();
    logic [3:0] exp;
    do_reset();
    eb[0] = 8'hA5; en = 1;
    load(1, 1);
    go();
    for (int c = 0; c <= 44; c++) begin
      exp = model(0, 1, c);
      vectors++;
      if ({tx[0], busy[0], bd[0], sent[0]} !== exp) begin
        errors++; $display("FAIL basic c=%0d got=%b exp=%b", c, {tx[0], busy[0], bd[0], sent[0]}, exp);
      end
      if (c == 10) ack = 1;
      step();
      ack = 0;
    end
  endtask
  task automatic test_parity();
    logic [3:0] e1, e2;
    do_reset();
    eb[0] = 8'h07; en = 1;
    load(1, 1);
    go();
    for (int c = 0; c <= 48; c++) begin
      e1 = model(1, 1, c);
      e2 = model(2, 1, c);
      vectors += 2;
      if ({tx[1], busy[1], bd[1], sent[1]} !== e1) begin
        errors++; $display("FAIL parity_even c=%0d got=%b exp=%b", c, {tx[1], busy[1], bd[1], sent[1]}, e1);
      end
      if ({tx[2], busy[2], bd[2], sent[2]} !== e2) begin
        errors++; $display("FAIL parity_odd c=%0d got=%b exp=%b", c, {tx[2], busy[2], bd[2], sent[2]}, e2);
      end
      if (c == 38) begin
        vectors++;
        if (tx[2:1] !== 2'b01) begin errors++; $display("FAIL parity_bit got=%b exp=01", tx[2:1]); end
      end
      step();
    end
  endtask
  task automatic test_two_stop();
    logic [3:0] exp;
    int pulses = 0;
    do_reset();
    eb[0] = 8'h00; eb[1] = 8'hFF; eb[2] = 8'h3C; en = 3;
    load(3, 3);
    go();
    for (int c = 0; c <= 136; c++) begin
      exp = model(0, 2, c);
      pulses += int'(bd[3]);
      vectors++;
      if ({tx[3], busy[3], bd[3], sent[3]} !== exp) begin
        errors++; $display("FAIL two_stop c=%0d got=%b exp=%b", c, {tx[3], busy[3], bd[3], sent[3]}, exp);
      end
      step();
    end
    vectors++;
    if (pulses !== 3) begin errors++; $display("FAIL two_stop_pulses got=%0d exp=3", pulses); end
  endtask
  task automatic test_full_burst(int lenv, string name);
    logic [3:0] exp;
    do_reset();
    for (int j = 0; j < 16; j++) eb[j] = 8'(j * 17) ^ 8'h5A;
    en = 16;
    load(16, lenv);
    go();
    for (int c = 0; c <= 645; c++) begin
      exp = model(0, 1, c);
      vectors++;
      if ({tx[0], busy[0], bd[0], sent[0]} !== exp) begin
        errors++; $display("FAIL %s c=%0d got=%b exp=%b", name, c, {tx[0], busy[0], bd[0], sent[0]}, exp);
      end
      if (c == 100) begin data = ~data; len = 5'd1; capture = 1; transmit = 1; end
      step();
      capture = 0; transmit = 0;
    end
  endtask
  task automatic test_reset_mid();
    logic [3:0] exp;
    do_reset();
    eb[0] = 8'h11; eb[1] = 8'h22; eb[2] = 8'h33; en = 3;
    load(3, 3);
    go();
    for (int c = 0; c <= 58; c++) begin
      exp = model(0, 1, c);
      vectors++;
      if ({tx[0], busy[0], bd[0], sent[0]} !== exp) begin
        errors++; $display("FAIL reset_mid_pre c=%0d got=%b exp=%b", c, {tx[0], busy[0], bd[0], sent[0]}, exp);
      end
      if (c < 58) step();
    end
    rst = 1;
    step();
    rst = 0;
    vectors++;
    if ({tx[0], busy[0], bd[0], sent[0]} !== 4'b1000) begin
      errors++; $display("FAIL reset_mid got=%b exp=1000", {tx[0], busy[0], bd[0], sent[0]});
    end
    for (int j = 0; j < 16; j++) eb[j] = 8'h00;
    en = 16;
    go();
    for (int c = 0; c <= 645; c++) begin
      exp = model(0, 1, c);
      vectors++;
      if ({tx[0], busy[0], bd[0], sent[0]} !== exp) begin
        errors++; $display("FAIL reset_restart c=%0d got=%b exp=%b", c, {tx[0], busy[0], bd[0], sent[0]}, exp);
      end
      step();
    end
  endtask
  task automatic test_done_handshake();
    logic [3:0] exp;
    do_reset();
    eb[0] = 8'h5A; en = 1;
    load(1, 1);
    go();
    for (int c = 0; c <= 41; c++) step();
    transmit = 1;
    step();
    transmit = 0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({tx[0], busy[0], sent[0]} !== 3'b101) begin
        errors++; $display("FAIL done_hold c=%0d got=%b exp=101", c, {tx[0], busy[0], sent[0]});
      end
      step();
    end
    ack = 1;
    step();
    ack = 0;
    vectors++;
    if (sent[0] !== 1'b0) begin errors++; $display("FAIL ack_sent got=%b exp=0", sent[0]); end
    eb[0] = 8'hC3; en = 1;
    data = '0; data[7:0] = 8'hC3; len = 5'd1;
    capture = 1; transmit = 1;
    step();
    capture = 0; transmit = 0;
    for (int c = 0; c <= 44; c++) begin
      exp = model(0, 1, c);
      vectors++;
      if ({tx[0], busy[0], bd[0], sent[0]} !== exp) begin
        errors++; $display("FAIL cap_tx c=%0d got=%b exp=%b", c, {tx[0], busy[0], bd[0], sent[0]}, exp);
      end
      step();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_full_burst(0, "len0_capture");
    test_full_burst(23, "len_saturate");
    test_reset_mid();
    test_done_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
